// File: rtl/cdda_serial_tx_if.sv
// CPU write port and serial audio outputs of the CD-DA transmitter.
// Master is the firmware/host side, slave is the transmitter.
interface cdda_serial_tx_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          enable;
    logic          clr;
    logic [7:0]    wr_data;
    logic          wr_stb;
    logic [LW-1:0] fifo_level;
    logic          fifo_full;
    logic          underrun;
    logic          overflow;
    logic          bck;
    logic          lrck;
    logic          sdat;

    modport master (
        output enable, clr, wr_data, wr_stb,
        input  fifo_level, fifo_full, underrun, overflow,
        input  bck, lrck, sdat
    );

    modport slave (
        input  enable, clr, wr_data, wr_stb,
        output fifo_level, fifo_full, underrun, overflow,
        output bck, lrck, sdat
    );
endinterface

// File: rtl/cdda_serial_tx.sv
// CD-DA serial transmitter: packs CPU bytes into stereo frames, queues
// them, and shifts them out left-justified MSB-first on bck/lrck/sdat.
module cdda_serial_tx #(
    parameter int BCK_DIV = 12,
    parameter int DEPTH   = 16
) (
    input  logic             clk,
    input  logic             nrst,
    cdda_serial_tx_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          bck_q, bck_d;
    logic          lrck_q, lrck_d;
    logic          sdat_q, sdat_d;
    logic [4:0]    bit_q, bit_d;
    logic [31:0]   sh_q, sh_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [23:0]   bbuf_q, bbuf_d;
    logic          urun_q, urun_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   mem_q [DEPTH];

    logic        empty;
    logic        full;
    logic        tc;
    logic        push_req;
    logic        push;
    logic        pop_req;
    logic        pop;
    logic [31:0] push_frame;
    logic [31:0] frame_in;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign tc    = (div_q == DW'(BCK_DIV - 1));

    assign push_req = bus.wr_stb && !bus.clr && (bcnt_q == 2'd3);
    assign push     = push_req && !full;
    // Slot boundary: LOAD, or the falling bck edge that wraps bit 31 -> 0
    assign pop_req  = bus.enable &&
                      ((state_q == LOAD) ||
                       ((state_q == RUN) && tc && bck_q &&
                        (bit_q == 5'd31)));
    assign pop      = pop_req && !empty && !bus.clr;

    assign push_frame = {bbuf_q[15:8], bbuf_q[7:0],
                         bus.wr_data, bbuf_q[23:16]};
    assign frame_in   = (empty || bus.clr) ? '0 : mem_q[rptr_q];

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bck_d   = bck_q;
        lrck_d  = lrck_q;
        sdat_d  = sdat_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        unique case (state_q)
            IDLE: begin
                div_d  = '0;
                bit_d  = '0;
                bck_d  = 1'b0;
                lrck_d = 1'b0;
                sdat_d = 1'b0;
                if (bus.enable) state_d = LOAD;
            end
            LOAD: begin
                sh_d    = frame_in;
                sdat_d  = frame_in[31];
                lrck_d  = 1'b0;
                bck_d   = 1'b0;
                div_d   = '0;
                bit_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (tc) begin
                    div_d = '0;
                    bck_d = !bck_q;
                    if (bck_q) begin
                        bit_d = bit_q + 5'd1;
                        if (bit_q == 5'd31) begin
                            sh_d   = frame_in;
                            sdat_d = frame_in[31];
                            lrck_d = 1'b0;
                        end else begin
                            sh_d   = {sh_q[30:0], 1'b0};
                            sdat_d = sh_q[30];
                            lrck_d = bit_d[4];
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (!bus.enable) begin
            state_d = IDLE;
            div_d   = '0;
            bit_d   = '0;
            bck_d   = 1'b0;
            lrck_d  = 1'b0;
            sdat_d  = 1'b0;
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        bcnt_d  = bcnt_q;
        bbuf_d  = bbuf_q;
        urun_d  = urun_q || (pop_req && empty);
        ovf_d   = ovf_q || (push_req && full);
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);
        if (bus.wr_stb) begin
            bcnt_d = bcnt_q + 2'd1;
            unique case (bcnt_q)
                2'd0:    bbuf_d[7:0]   = bus.wr_data;
                2'd1:    bbuf_d[15:8]  = bus.wr_data;
                2'd2:    bbuf_d[23:16] = bus.wr_data;
                default: ;
            endcase
        end
        if (bus.clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            bcnt_d  = '0;
            urun_d  = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= push_frame;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bck_q   <= 1'b0;
            lrck_q  <= 1'b0;
            sdat_q  <= 1'b0;
            bit_q   <= '0;
            sh_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            bcnt_q  <= '0;
            bbuf_q  <= '0;
            urun_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bck_q   <= bck_d;
            lrck_q  <= lrck_d;
            sdat_q  <= sdat_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            bcnt_q  <= bcnt_d;
            bbuf_q  <= bbuf_d;
            urun_q  <= urun_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.fifo_level = level_q;
    assign bus.fifo_full  = full;
    assign bus.underrun   = urun_q;
    assign bus.overflow   = ovf_q;
    assign bus.bck        = bck_q;
    assign bus.lrck       = lrck_q;
    assign bus.sdat       = sdat_q;
endmodule
